// File: rtl/volume_step_if.sv
// volume_step_if: button and indicator signals of the volume step controller.
// Signals:
//   up_btn, down_btn, mute_btn  debounced button levels (master -> slave)
//   volume_level[7:0]           level shown on the indicator (slave -> master)
//   muted, at_max, at_min       status flags (slave -> master)
//   step_pulse                  one-cycle pulse on every level change (slave -> master)
interface volume_step_if;
    logic       up_btn;
    logic       down_btn;
    logic       mute_btn;
    logic [7:0] volume_level;
    logic       muted;
    logic       at_max;
    logic       at_min;
    logic       step_pulse;
    modport master(output up_btn, down_btn, mute_btn,
                   input volume_level, muted, at_max, at_min, step_pulse);
    modport slave(input up_btn, down_btn, mute_btn,
                  output volume_level, muted, at_max, at_min, step_pulse);
endinterface

// File: rtl/volume_step_controller.sv
// volume_step_controller: turns held up/down buttons into saturating volume steps
// with auto-repeat, plus optional mute.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   volume_step_if.slave: buttons in; volume_level, muted, at_max, at_min,
//         step_pulse out (all registered)
// Configuration: define VOL_MUTE_EN to build the mute logic; otherwise mute_btn is
// ignored and muted stays 0.
module volume_step_controller #(
    parameter int MAX_LEVEL    = 8,
    parameter int RESET_LEVEL  = 3,
    parameter int REPEAT_DELAY = 16,
    parameter int REPEAT_RATE  = 4
) (
    input logic          clk,
    input logic          rst,
    volume_step_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
    localparam logic [7:0]  MAX_L    = 8'(MAX_LEVEL);
    localparam logic [15:0] DELAY_M1 = 16'(REPEAT_DELAY - 1);
    localparam logic [15:0] RATE_M1  = 16'(REPEAT_RATE - 1);
    state_t      state_q, state_d;
    logic [7:0]  level_q, level_d, stepped, vol_q;
    logic [15:0] cnt_q, cnt_d;
    logic        up_dly_q, down_dly_q, dir_q, dir_d;
    logic        muted_q, muted_d, at_max_q, at_min_q, step_q;
    logic        up_edge, down_edge, held, other, do_step, mute_block;
    assign up_edge   = bus.up_btn & ~up_dly_q;
    assign down_edge = bus.down_btn & ~down_dly_q;
    assign held      = dir_q ? bus.up_btn : bus.down_btn;
    assign other     = dir_q ? bus.down_btn : bus.up_btn;
`ifdef VOL_MUTE_EN
    logic mute_dly_q, mute_edge;
    assign mute_edge  = bus.mute_btn & ~mute_dly_q;
    assign muted_d    = muted_q ^ mute_edge;
    // A mute edge wins over a simultaneous press; while muted every press is dropped.
    assign mute_block = muted_q | mute_edge;
    always_ff @(posedge clk) begin
        mute_dly_q <= rst ? 1'b0 : bus.mute_btn;
    end
`else
    logic mute_unused;
    assign mute_unused = bus.mute_btn;
    assign muted_d     = 1'b0;
    assign mute_block  = 1'b0;
`endif
    // Direction comes from dir_d so a press step uses the freshly latched direction.
    assign stepped = dir_d ? ((level_q == MAX_L) ? level_q : level_q + 8'd1)
                           : ((level_q == 8'd0) ? level_q : level_q - 8'd1);
    assign level_d = do_step ? stepped : level_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        do_step = 1'b0;
        if (state_q == IDLE) begin
            if (!mute_block && ((up_edge && !bus.down_btn) || (down_edge && !bus.up_btn))) begin
                do_step = 1'b1;
                dir_d   = up_edge;
                cnt_d   = '0;
                state_d = HOLD;
            end
        end else if (mute_block || !held || other) begin
            cnt_d   = '0;
            state_d = IDLE;
        end else if (cnt_q == ((state_q == HOLD) ? DELAY_M1 : RATE_M1)) begin
            do_step = 1'b1;
            cnt_d   = '0;
            state_d = REPEAT;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dir_q      <= 1'b0;
            level_q    <= 8'(RESET_LEVEL);
            up_dly_q   <= 1'b0;
            down_dly_q <= 1'b0;
            muted_q    <= 1'b0;
            vol_q      <= 8'(RESET_LEVEL);
            at_max_q   <= (RESET_LEVEL == MAX_LEVEL);
            at_min_q   <= (RESET_LEVEL == 0);
            step_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            level_q    <= level_d;
            up_dly_q   <= bus.up_btn;
            down_dly_q <= bus.down_btn;
            muted_q    <= muted_d;
            vol_q      <= muted_d ? 8'd0 : level_d;
            at_max_q   <= (level_d == MAX_L);
            at_min_q   <= (level_d == 8'd0);
            step_q     <= (level_d != level_q);
        end
    end
    assign bus.volume_level = vol_q;
    assign bus.muted        = muted_q;
    assign bus.at_max       = at_max_q;
    assign bus.at_min       = at_min_q;
    assign bus.step_pulse   = step_q;
endmodule
